// File: rtl/parking_pkg.sv
// Shared constants and state encoding for the parking gate controller.
// These values are reused by the slot display path.
package parking_pkg;

  localparam int NUM_SLOTS_DEFAULT    = 15;
  localparam int CW_DEFAULT           = $clog2(NUM_SLOTS_DEFAULT + 1);
  localparam int GATE_TIMEOUT_DEFAULT = 500_000_000;
  localparam int CLOSE_CYCLES_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN,
    COOLDOWN
  } gate_state_t;

endpackage

// File: rtl/slot_popcount.sv
// Combinational count of occupied slots. The display path reuses this block,
// so it stays free of registers.
module slot_popcount #(
  parameter int N = 15,
  parameter int W = 4
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  logic [W-1:0] count_next;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + W'(bits[i]);
    end
  end

  assign count = count_next;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Shared entry/exit barrier controller. It arbitrates requests, sequences the
// gates, and reserves a slot for every admitted car until that car parks.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS    = NUM_SLOTS_DEFAULT,
  parameter int CW           = CW_DEFAULT,
  parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEFAULT,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] slot_occ,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic                 pass_entry,
  input  logic                 pass_exit,
  output logic                 entry_gate_open,
  output logic                 exit_gate_open,
  output logic [CW-1:0]        free_count,
  output logic                 full,
  output logic                 deny,
  output logic                 timeout_err
);

  localparam int TMAX = (GATE_TIMEOUT > CLOSE_CYCLES) ? GATE_TIMEOUT : CLOSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GATE_LAST  = TW'(GATE_TIMEOUT - 1);
  localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
  localparam logic [CW:0]   SLOTS_W    = (CW+1)'(NUM_SLOTS);

  // Control sync bit order: {pass_exit, pass_entry, exit_req, entry_req}
  logic [NUM_SLOTS-1:0] occ_meta_reg, occ_sync_reg;
  logic [3:0]           ctl_meta_reg, ctl_sync_reg;
  logic [1:0]           pass_prev_reg;

  logic [CW-1:0] occ_now, occ_reg, occ_prev_reg;
  logic [CW-1:0] reserved_reg, reserved_next;
  logic [CW-1:0] free_reg, free_next;
  logic          full_reg, deny_reg, timeout_reg;
  logic          entry_gate_reg, exit_gate_reg;

  gate_state_t   state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          last_entry_reg, last_entry_next;
  logic          reserve, timeout_hit;

  logic entry_req_s, exit_req_s, entry_rise, exit_rise, entry_ok;
  assign entry_req_s = ctl_sync_reg[0];
  assign exit_req_s  = ctl_sync_reg[1];
  assign entry_rise  = ctl_sync_reg[2] & ~pass_prev_reg[0];
  assign exit_rise   = ctl_sync_reg[3] & ~pass_prev_reg[1];
  assign entry_ok    = entry_req_s & ~full_reg;

  slot_popcount #(.N(NUM_SLOTS), .W(CW)) u_popcount (
    .bits  (occ_sync_reg),
    .count (occ_now)
  );

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg + TW'(1);
    last_entry_next = last_entry_reg;
    reserve         = 1'b0;
    timeout_hit     = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (entry_ok && exit_req_s) state_next = last_entry_reg ? EXIT_OPEN : ENTRY_OPEN;
        else if (exit_req_s)        state_next = EXIT_OPEN;
        else if (entry_ok)          state_next = ENTRY_OPEN;
      end
      ENTRY_OPEN: begin
        // A pass in the timeout cycle wins over the timeout.
        if (entry_rise) begin
          reserve         = 1'b1;
          last_entry_next = 1'b1;
          state_next      = COOLDOWN;
          timer_next      = '0;
        end else if (timer_reg == GATE_LAST) begin
          timeout_hit = 1'b1;
          state_next  = COOLDOWN;
          timer_next  = '0;
        end
      end
      EXIT_OPEN: begin
        if (exit_rise) begin
          last_entry_next = 1'b0;
          state_next      = COOLDOWN;
          timer_next      = '0;
        end else if (timer_reg == GATE_LAST) begin
          timeout_hit = 1'b1;
          state_next  = COOLDOWN;
          timer_next  = '0;
        end
      end
      COOLDOWN: begin
        if (timer_reg == CLOSE_LAST) begin
          state_next = IDLE;
          timer_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Parked cars release their reservation; free_count uses the post-update
  // reservation so it does not dip while a reserved car lands in a slot.
  logic [CW-1:0] delta, dec;
  logic [CW:0]   res_sum, used;
  always_comb begin
    delta         = (occ_reg > occ_prev_reg) ? (occ_reg - occ_prev_reg) : '0;
    dec           = (delta < reserved_reg) ? delta : reserved_reg;
    res_sum       = {1'b0, reserved_reg - dec} + {{CW{1'b0}}, reserve};
    reserved_next = (res_sum > SLOTS_W) ? CW'(NUM_SLOTS) : res_sum[CW-1:0];
    used          = {1'b0, occ_reg} + {1'b0, reserved_next};
    free_next     = (used >= SLOTS_W) ? '0 : CW'(SLOTS_W - used);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_meta_reg   <= '0;
      occ_sync_reg   <= '0;
      ctl_meta_reg   <= '0;
      ctl_sync_reg   <= '0;
      pass_prev_reg  <= '0;
      occ_reg        <= '0;
      occ_prev_reg   <= '0;
      reserved_reg   <= '0;
      free_reg       <= CW'(NUM_SLOTS);
      full_reg       <= 1'b0;
      deny_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      entry_gate_reg <= 1'b0;
      exit_gate_reg  <= 1'b0;
      state_reg      <= IDLE;
      timer_reg      <= '0;
      last_entry_reg <= 1'b0;
    end else begin
      occ_meta_reg   <= slot_occ;
      occ_sync_reg   <= occ_meta_reg;
      ctl_meta_reg   <= {pass_exit, pass_entry, exit_req, entry_req};
      ctl_sync_reg   <= ctl_meta_reg;
      pass_prev_reg  <= ctl_sync_reg[3:2];
      occ_reg        <= occ_now;
      occ_prev_reg   <= occ_reg;
      reserved_reg   <= reserved_next;
      free_reg       <= free_next;
      full_reg       <= (free_next == '0);
      deny_reg       <= (state_reg == IDLE) && entry_req_s && full_reg;
      timeout_reg    <= timeout_hit;
      entry_gate_reg <= (state_reg == ENTRY_OPEN);
      exit_gate_reg  <= (state_reg == EXIT_OPEN);
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      last_entry_reg <= last_entry_next;
    end
  end

  assign entry_gate_open = entry_gate_reg;
  assign exit_gate_open  = exit_gate_reg;
  assign free_count      = free_reg;
  assign full            = full_reg;
  assign deny            = deny_reg;
  assign timeout_err     = timeout_reg;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with short timeout/close settings:
// a steady-state vector table plus cycle-exact hand sequences.
module tb_parking_gate_ctrl;

  localparam int NS  = 15;
  localparam int CWT = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS-1:0]  slot_occ;
  logic           entry_req, exit_req, pass_entry, pass_exit;
  logic           entry_gate_open, exit_gate_open, full, deny, timeout_err;
  logic [CWT-1:0] free_count;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  typedef struct {
    logic [NS-1:0] occ;
    logic          ent;
    logic          ext;
    int            free;
    logic          full;
    logic          deny;
    logic          eg;
    logic          xg;
  } vec_t;

  vec_t vecs [9];

  parking_gate_ctrl #(
    .NUM_SLOTS    (NS),
    .CW           (CWT),
    .GATE_TIMEOUT (20),
    .CLOSE_CYCLES (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .slot_occ        (slot_occ),
    .entry_req       (entry_req),
    .exit_req        (exit_req),
    .pass_entry      (pass_entry),
    .pass_exit       (pass_exit),
    .entry_gate_open (entry_gate_open),
    .exit_gate_open  (exit_gate_open),
    .free_count      (free_count),
    .full            (full),
    .deny            (deny),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && entry_gate_open && exit_gate_open) overlap++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [NS-1:0] occ);
    rst_n = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; pass_entry = 1'b0; pass_exit = 1'b0;
    slot_occ = occ;
    tick(2);
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic wait_open(input int budget, output int side);
    side = 0;
    for (int c = 0; c < budget && side == 0; c++) begin
      tick(1);
      if (entry_gate_open) side = 1;
      else if (exit_gate_open) side = 2;
    end
  endtask

  int side, first_open, to_idx, pulses, open_cnt, reopen;

  initial begin
    vecs[0] = '{15'h0000, 1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{15'h0001, 1'b1, 1'b0, 14, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{15'h7FFF, 1'b1, 1'b0,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{15'h7FFF, 1'b0, 1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{15'h00FF, 1'b1, 1'b1,  7, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{15'h5555, 1'b0, 1'b1,  7, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{15'h7FFE, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{15'h7FFF, 1'b0, 1'b0,  0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{15'h0000, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; pass_entry = 1'b0; pass_exit = 1'b0;
    slot_occ = '0;
    tick(2);
    chk("rst_entry_gate", entry_gate_open, 0);
    chk("rst_exit_gate", exit_gate_open, 0);
    chk("rst_free", free_count, 15);
    chk("rst_full", full, 0);
    chk("rst_deny", deny, 0);
    chk("rst_timeout", timeout_err, 0);

    // Steady-state table: occupancy settles first, then requests are applied
    for (int i = 0; i < 9; i++) begin
      do_reset(vecs[i].occ);
      entry_req = vecs[i].ent;
      exit_req  = vecs[i].ext;
      tick(6);
      chk($sformatf("vec%0d_free", i), free_count, vecs[i].free);
      chk($sformatf("vec%0d_full", i), full, vecs[i].full);
      chk($sformatf("vec%0d_deny", i), deny, vecs[i].deny);
      chk($sformatf("vec%0d_entry_gate", i), entry_gate_open, vecs[i].eg);
      chk($sformatf("vec%0d_exit_gate", i), exit_gate_open, vecs[i].xg);
      $display("vec %0d occ=%h ent=%0b ext=%0b free=%0d full=%0b deny=%0b eg=%0b xg=%0b",
               i, vecs[i].occ, vecs[i].ent, vecs[i].ext, free_count, full, deny,
               entry_gate_open, exit_gate_open);
      entry_req = 1'b0;
      exit_req  = 1'b0;
    end

    // Entry pulse, pass six cycles later, then the car parks in slot 3
    do_reset('0);
    entry_req = 1'b1; tick(1); entry_req = 1'b0; tick(2);
    chk("entry_gate_before_3", entry_gate_open, 0);
    tick(1);
    chk("entry_gate_at_3", entry_gate_open, 1);
    tick(2);
    pass_entry = 1'b1; tick(3);
    chk("entry_gate_pass_2", entry_gate_open, 1);
    chk("entry_pass_free", free_count, 14);
    tick(1);
    chk("entry_gate_pass_3", entry_gate_open, 0);
    pass_entry = 1'b0;
    tick(8);
    $display("entry pass free=%0d", free_count);
    slot_occ = 15'h0008;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk($sformatf("park_free_c%0d", c), free_count, 14);
    end
    slot_occ = '0;
    tick(6);
    chk("reserve_released", free_count, 15);
    $display("parked then left free=%0d", free_count);

    // Full lot: entry denied, exit still served
    do_reset(15'h7FFF);
    entry_req = 1'b1; tick(6);
    chk("full_deny", deny, 1);
    chk("full_entry_gate", entry_gate_open, 0);
    exit_req = 1'b1; tick(4);
    chk("full_exit_gate", exit_gate_open, 1);
    chk("full_entry_still_closed", entry_gate_open, 0);
    $display("full lot exit_gate=%0b entry_gate=%0b", exit_gate_open, entry_gate_open);
    entry_req = 1'b0; exit_req = 1'b0;

    // Simultaneous requests twice: entry first, then exit
    do_reset('0);
    entry_req = 1'b1; exit_req = 1'b1;
    wait_open(10, side);
    chk("tie1_side", side, 1);
    pass_entry = 1'b1; tick(2); pass_entry = 1'b0; tick(2);
    chk("tie1_closed", entry_gate_open, 0);
    wait_open(20, side);
    chk("tie2_side", side, 2);
    pass_exit = 1'b1; tick(2); pass_exit = 1'b0; tick(2);
    chk("tie2_closed", exit_gate_open, 0);
    $display("tie sequence second side=%0d", side);
    entry_req = 1'b0; exit_req = 1'b0;

    // Timeout: 20 open cycles, one pulse, 5 cooldown cycles, then regrant
    do_reset('0);
    first_open = 0; to_idx = 0; pulses = 0; open_cnt = 0; reopen = 0;
    entry_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (timeout_err) begin
        pulses++;
        if (to_idx == 0) to_idx = c;
      end
      if (entry_gate_open && c <= 29) open_cnt++;
      if (entry_gate_open && first_open == 0) first_open = c;
      if (c == 30) reopen = entry_gate_open;
    end
    chk("to_first_open", first_open, 4);
    chk("to_pulse_cycle", to_idx, 23);
    chk("to_pulse_count", pulses, 1);
    chk("to_open_cycles", open_cnt, 20);
    chk("to_reopen", reopen, 1);
    chk("to_free_unreserved", free_count, 15);
    $display("timeout at cycle %0d pulses=%0d", to_idx, pulses);
    entry_req = 1'b0;

    // Reset while exit gate open, with one car reserved in transit
    do_reset(15'h0003);
    entry_req = 1'b1; tick(1); entry_req = 1'b0; tick(5);
    pass_entry = 1'b1; tick(2); pass_entry = 1'b0; tick(10);
    chk("mid_free_reserved", free_count, 12);
    exit_req = 1'b1; tick(4);
    chk("mid_exit_open", exit_gate_open, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_exit_closed", exit_gate_open, 0);
    chk("mid_async_free", free_count, 15);
    exit_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(6);
    chk("mid_after_exit_gate", exit_gate_open, 0);
    chk("mid_after_entry_gate", entry_gate_open, 0);
    chk("mid_after_free", free_count, 13);
    $display("reset mid-exit free=%0d", free_count);

    chk("gates_exclusive", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
